clock_divider_multi: RTL and testbench

Parametrised, multi-channel successor to the fixed single-output divider (13 Hz from 100 MHz).
- NCH independent channels share one clock_in.
- Each channel has a runtime-loadable divisor, square or single-cycle-pulse output mode, a per-channel enable, and a wrap tick.
- New divisors are applied glitch-free at the next period boundary.
- Feeds display scanning, debouncers and blinkers that today each instantiate a fixed divider.

---
 rtl/clock_divider_multi.sv | 122 ++++++++++++
 tb/tb_clock_divider_multi.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider.
// Each channel counts clock_in cycles up to its divisor and produces either a
// square wave or a single-cycle pulse, plus a wrap tick. New divisors are
// staged as pending loads and take effect at the next period boundary, or
// immediately while the channel is disabled.
module clock_divider_multi #(
  parameter int unsigned      WIDTH       = 28,
  parameter int unsigned      NCH         = 4,
  parameter int unsigned      SELW        = 2,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(7692307)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic [NCH-1:0]   enable,
  input  logic             load,
  input  logic [SELW-1:0]  load_sel,
  input  logic [WIDTH-1:0] load_div,
  input  logic             load_mode,
  output logic [NCH-1:0]   load_pending,
  output logic             load_err,
  output logic [NCH-1:0]   clock_out,
  output logic [NCH-1:0]   tick
);

  logic [WIDTH-1:0] cnt_q      [NCH];
  logic [WIDTH-1:0] cnt_d      [NCH];
  logic [WIDTH-1:0] div_q      [NCH];
  logic [WIDTH-1:0] div_d      [NCH];
  logic [WIDTH-1:0] pend_div_q [NCH];
  logic [WIDTH-1:0] pend_div_d [NCH];
  logic [NCH-1:0]   mode_q, mode_d;
  logic [NCH-1:0]   pend_mode_q, pend_mode_d;
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   clk_q, clk_d;
  logic [NCH-1:0]   tick_q, tick_d;
  logic             err_q, err_d;
  logic [NCH-1:0]   wrap;
  logic             load_ok;

  // Load validation and per-channel period-end detection (>= tolerates cnt overshoot)
  always_comb begin
    load_ok = load && (load_div >= WIDTH'(2)) && (32'(load_sel) < NCH);
    err_d   = load && !load_ok;
    for (int unsigned i = 0; i < NCH; i++) begin
      wrap[i] = cnt_q[i] >= (div_q[i] - WIDTH'(1));
    end
  end

  // Next-state for counters, divisor/mode registers, staged loads and outputs
  always_comb begin
    cnt_d       = cnt_q;
    div_d       = div_q;
    pend_div_d  = pend_div_q;
    mode_d      = mode_q;
    pend_mode_d = pend_mode_q;
    pending_d   = pending_q;
    clk_d       = '0;
    tick_d      = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!enable[i]) begin
        cnt_d[i] = '0;
        if (pending_q[i]) begin
          div_d[i]     = pend_div_q[i];
          mode_d[i]    = pend_mode_q[i];
          pending_d[i] = 1'b0;
        end
      end else begin
        tick_d[i] = wrap[i];
        clk_d[i]  = mode_q[i] ? wrap[i] : (cnt_q[i] < (div_q[i] >> 1));
        if (wrap[i]) begin
          cnt_d[i] = '0;
          if (pending_q[i]) begin
            div_d[i]     = pend_div_q[i];
            mode_d[i]    = pend_mode_q[i];
            pending_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end
      // A load landing on the same cycle as an apply re-arms pending with the new value
      if (load_ok && (32'(load_sel) == i)) begin
        pend_div_d[i]  = load_div;
        pend_mode_d[i] = load_mode;
        pending_d[i]   = 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock_in) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i]      <= '0;
        div_q[i]      <= DEFAULT_DIV;
        pend_div_q[i] <= DEFAULT_DIV;
      end
      mode_q      <= '0;
      pend_mode_q <= '0;
      pending_q   <= '0;
      clk_q       <= '0;
      tick_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      pend_div_q  <= pend_div_d;
      mode_q      <= mode_d;
      pend_mode_q <= pend_mode_d;
      pending_q   <= pending_d;
      clk_q       <= clk_d;
      tick_q      <= tick_d;
      err_q       <= err_d;
    end
  end

  assign load_pending = pending_q;
  assign load_err     = err_q;
  assign clock_out    = clk_q;
  assign tick         = tick_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: a 4-channel and a 3-channel instance share
// one stimulus bus. Expected periods/high-times and load_err pulses are queued
// by the stimulus; a negedge monitor measures each tick-to-tick interval.
module tb_clock_divider_multi;
  localparam int unsigned W = 28;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   enable;
  logic         load;
  logic [1:0]   load_sel;
  logic [W-1:0] load_div;
  logic         load_mode;
  logic [3:0]   pend4, co4, tk4;
  logic         err4;
  logic [2:0]   pend3, co3, tk3;
  logic         err3;

  always #5 clk = ~clk;

  clock_divider_multi #(.WIDTH(W), .NCH(4), .SELW(2), .DEFAULT_DIV(W'(10))) u_dut (
    .clock_in(clk), .reset(reset), .enable(enable), .load(load),
    .load_sel(load_sel), .load_div(load_div), .load_mode(load_mode),
    .load_pending(pend4), .load_err(err4), .clock_out(co4), .tick(tk4)
  );

  clock_divider_multi #(.WIDTH(W), .NCH(3), .SELW(2), .DEFAULT_DIV(W'(10))) u_dut3 (
    .clock_in(clk), .reset(reset), .enable(enable[2:0]), .load(load),
    .load_sel(load_sel), .load_div(load_div), .load_mode(load_mode),
    .load_pending(pend3), .load_err(err3), .clock_out(co3), .tick(tk3)
  );

  typedef struct {
    int unsigned per;
    int unsigned hi;
    bit          pulse;
  } exp_t;

  exp_t        expq [4][$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int          exp_err4 = 0;
  int          exp_err3 = 0;
  int unsigned cyc [4];
  int unsigned hic [4];
  logic        rst_d = 1'b1;
  logic [3:0]  en_d = '0;

  // Values the DUT actually sampled at the last rising edge
  always @(posedge clk) begin
    rst_d <= reset;
    en_d  <= enable;
  end

  // Monitor: measure each interval between ticks and score it against the queue
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (rst_d || !en_d[i]) begin
        cyc[i] = 0;
        hic[i] = 0;
      end else begin
        cyc[i]++;
        if (co4[i]) hic[i]++;
        if (tk4[i]) begin
          if (expq[i].size() > 0) begin
            e = expq[i].pop_front();
            vectors++;
            if (cyc[i] != e.per || hic[i] != e.hi || (e.pulse && !co4[i])) begin
              miscompares++;
              $display("FAIL period ch%0d: got period %0d high %0d pulse_at_tick %0b, required period %0d high %0d pulse %0b",
                       i, cyc[i], hic[i], co4[i], e.per, e.hi, e.pulse);
            end
          end
          cyc[i] = 0;
          hic[i] = 0;
        end
      end
    end
    if (err4 === 1'b1) begin
      vectors++;
      if (exp_err4 > 0) exp_err4--;
      else begin
        miscompares++;
        $display("FAIL load_err dut4: got 1 required 0");
      end
    end
    if (err3 === 1'b1) begin
      vectors++;
      if (exp_err3 > 0) exp_err3--;
      else begin
        miscompares++;
        $display("FAIL load_err dut3: got 1 required 0");
      end
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push(input int ch, input int unsigned per, input int unsigned hi,
                      input bit pulse, input int n);
    for (int k = 0; k < n; k++) expq[ch].push_back('{per, hi, pulse});
  endtask

  task automatic do_load(input logic [1:0] sel, input logic [W-1:0] dv, input logic md);
    @(posedge clk);
    #2;
    load = 1'b1; load_sel = sel; load_div = dv; load_mode = md;
    @(posedge clk);
    #2;
    load = 1'b0;
  endtask

  task automatic wait_tick(input int ch);
    bit seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (tk4[ch] === 1'b1) seen = 1;
    end
    #1;
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_tick ch%0d: got no tick required tick within 300 cycles", ch);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      #1;
      done = (expq[0].size() == 0) && (expq[1].size() == 0) && (expq[2].size() == 0) &&
             (expq[3].size() == 0) && (exp_err4 == 0) && (exp_err3 == 0);
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL drain %s: got %0d/%0d/%0d/%0d periods and %0d/%0d errs outstanding required 0",
               name, expq[0].size(), expq[1].size(), expq[2].size(), expq[3].size(), exp_err4, exp_err3);
      for (int i = 0; i < 4; i++) expq[i].delete();
      exp_err4 = 0;
      exp_err3 = 0;
    end
  endtask

  initial begin
    reset = 1'b1; enable = '0; load = 1'b0; load_sel = '0; load_div = '0; load_mode = 1'b0;

    // Reset defaults
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst clock_out", co4, 0);
    chk("rst tick", tk4, 0);
    chk("rst pending", pend4, 0);
    chk("rst load_err", err4, 0);
    @(posedge clk);
    #2;
    reset = 1'b0; enable = 4'hF;
    for (int c = 0; c < 4; c++) push(c, 10, 5, 0, 3);
    wait_drain("default");
    chk("pending after defaults", pend4, 0);

    // Odd divisor on channel 1, others stay at 10
    do_load(2'd1, W'(7), 1'b0);
    chk("pending ch1 load", pend4, 4'b0010);
    push(1, 10, 5, 0, 1);
    push(1, 7, 3, 0, 3);
    push(0, 10, 5, 0, 2);
    push(2, 10, 5, 0, 2);
    push(3, 10, 5, 0, 2);
    wait_drain("odd div");

    // Mid-period load on channel 0 at cnt=2
    wait_tick(0);
    @(posedge clk);
    do_load(2'd0, W'(4), 1'b0);
    chk("pending ch0 mid", pend4, 4'b0001);
    push(0, 10, 5, 0, 1);
    push(0, 4, 2, 0, 3);
    repeat (6) @(posedge clk);
    #2;
    chk("pending ch0 before wrap", pend4, 4'b0001);
    wait_tick(0);
    chk("pending ch0 after wrap", pend4, 0);
    wait_drain("mid load");

    // Pulse mode on channel 2
    do_load(2'd2, W'(3), 1'b1);
    push(2, 10, 5, 0, 1);
    push(2, 3, 1, 1, 4);
    wait_drain("pulse");

    // Rejections: divisor 1 on both instances, channel 3 on the 3-channel one
    exp_err4++;
    exp_err3++;
    do_load(2'd0, W'(1), 1'b0);
    chk("pending after div=1", pend4, 0);
    chk("dut3 pending after div=1", pend3, 0);
    exp_err3++;
    do_load(2'd3, W'(10), 1'b0);
    chk("pending after sel=3", pend4, 4'b1000);
    chk("dut3 pending after sel=3", pend3, 0);
    push(0, 4, 2, 0, 2);
    push(1, 7, 3, 0, 2);
    push(2, 3, 1, 1, 2);
    wait_drain("reject");

    // Disable channel 3 at cnt=6, load while disabled, re-enable
    wait_tick(3);
    repeat (6) @(posedge clk);
    #2;
    enable[3] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("disabled clock_out3", co4[3], 0);
    chk("disabled tick3", tk4[3], 0);
    exp_err3++;
    do_load(2'd3, W'(6), 1'b0);
    chk("pending ch3 disabled", pend4, 4'b1000);
    @(posedge clk);
    #2;
    chk("pending ch3 applied", pend4, 0);
    @(posedge clk);
    #2;
    enable[3] = 1'b1;
    push(3, 6, 3, 0, 2);
    wait_drain("re-enable");

    // Reset while channel 0 holds a pending load
    wait_tick(0);
    do_load(2'd0, W'(5), 1'b0);
    chk("pending before reset", pend4, 4'b0001);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset pending", pend4, 0);
    chk("reset clock_out", co4, 0);
    chk("reset tick", tk4, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) push(c, 10, 5, 0, 2);
    wait_drain("post reset");

    chk("leftover err4", exp_err4, 0);
    chk("leftover err3", exp_err3, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
